// File: rtl/dcache_wb_controller_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller.
package dcache_wb_controller_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } state_e;

  localparam int unsigned OFFSET_W     = 5;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned WORD_SEL_LSB = 2;
  localparam int unsigned WORD_SEL_W   = 3;

  function automatic int unsigned index_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read, synchronous write at a shared index.
module dcache_sram
  import dcache_wb_controller_pkg::*;
#(
  parameter int unsigned LINES   = 16,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 23,
  parameter int unsigned LINE_W  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_data,
  input  logic                  fill_we,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_W-1:0]     fill_data,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0]     word_data,
  input  logic                  clean_we
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end else if (clean_we) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (word_we) begin
      data_q[idx][{word_sel, 5'd0} +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_wb_controller.sv
// Direct-mapped write-back, write-allocate data cache controller for the MEM stage.
module dcache_wb_controller
  import dcache_wb_controller_pkg::*;
#(
  parameter int unsigned LINES  = 16,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int unsigned INDEX_W = index_width(LINES);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

  state_e                  state_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [INDEX_W-1:0]      idx;
  logic [TAG_W-1:0]        req_tag;
  logic [WORD_SEL_W-1:0]   word_sel;
  logic                    rd_valid;
  logic                    rd_dirty;
  logic [TAG_W-1:0]        rd_tag;
  logic [LINE_W-1:0]       rd_data;
  logic                    hit;
  logic                    fill_we;
  logic                    word_we;
  logic                    clean_we;
  logic [WORD_SEL_LSB-1:0] unused_byte_sel;

  assign idx             = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign req_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign word_sel        = cpu_addr_i[WORD_SEL_LSB +: WORD_SEL_W];
  assign unused_byte_sel = cpu_addr_i[WORD_SEL_LSB-1:0];

  assign hit         = cpu_req_i & rd_valid & (rd_tag == req_tag);
  assign cpu_stall_o = cpu_req_i & ((state_q != StIdle) | ~hit);
  assign cpu_data_o  = hit ? rd_data[{word_sel, 5'd0} +: WORD_W] : '0;

  assign word_we  = (state_q == StIdle) & hit & cpu_we_i;
  assign clean_we = (state_q == StWriteback) & mem_ack_i;
  assign fill_we  = (state_q == StAllocate) & mem_ack_i;

  assign mem_req_o = mem_req_q;
  assign mem_we_o  = mem_we_q;

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    unique case (state_q)
      StWriteback: begin
        mem_addr_o = {rd_tag, idx, {OFFSET_W{1'b0}}};
        mem_data_o = rd_data;
      end
      StAllocate: mem_addr_o = {req_tag, idx, {OFFSET_W{1'b0}}};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_req_i && !hit) begin
            mem_req_q <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state_q  <= StWriteback;
              mem_we_q <= 1'b1;
            end else begin
              state_q  <= StAllocate;
              mem_we_q <= 1'b0;
            end
          end
        end
        StWriteback: begin
          if (mem_ack_i) begin
            state_q  <= StAllocate;
            mem_we_q <= 1'b0;
          end
        end
        StAllocate: begin
          if (mem_ack_i) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  dcache_sram #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_data (mem_data_i),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (cpu_data_i),
    .clean_we  (clean_we)
  );

endmodule

// File: tb/tb_dcache_wb_controller.sv
// Randomized bench: flat golden memory plus a line-level cache model predict hits and traffic.
module tb_dcache_wb_controller;

  localparam int LINES = 16;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
    int           lat;
  } txn_t;

  txn_t         txn_q[$];
  logic [31:0]  golden  [logic [31:0]];
  logic [255:0] backing [logic [31:0]];
  bit           m_valid [LINES];
  bit           m_dirty [LINES];
  logic [22:0]  m_tag   [LINES];

  int n_cmp = 0;
  int n_err = 0;
  int fixed_lat = 0;
  bit hold_ack = 0;
  int stray_cnt = 0;

  always #5 clk_i = ~clk_i;

  dcache_wb_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000 ^ (a << 11);
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = gold_word(la + 32'(4 * w));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(4 * w));
    return l;
  endfunction

  // Off-chip memory: acks each request after a latency of 1..5 cycles (or fixed_lat).
  initial begin
    int resp_cnt;
    int resp_lat;
    int stray_done;
    resp_cnt   = 0;
    resp_lat   = 1;
    stray_done = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (rst_i) begin
        resp_cnt = 0;
      end else if (stray_done != stray_cnt) begin
        mem_ack_i  = 1'b1;
        mem_data_i = {8{$urandom}};
        stray_done = stray_cnt;
      end else if (mem_req_o && !hold_ack) begin
        if (resp_cnt == 0) resp_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 5));
        resp_cnt++;
        if (resp_cnt == resp_lat) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) backing[mem_addr_o] = mem_data_o;
          else mem_data_i = mem_line(mem_addr_o);
          txn_q.push_back('{we: mem_we_o, addr: mem_addr_o,
                            data: mem_we_o ? mem_data_o : '0, lat: resp_lat});
          resp_cnt = 0;
        end
      end
    end
  end

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int          idx;
    int          start;
    int          stalls;
    int          sum_lat;
    int          n_exp;
    bit          hit;
    logic [22:0] tg;
    logic [31:0] waddr;
    logic [31:0] laddr;
    logic [31:0] vaddr;
    waddr = addr & ~32'h3;
    laddr = addr & ~32'h1F;
    idx   = int'(addr[8:5]);
    tg    = addr[31:9];
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    vaddr = {m_tag[idx], addr[8:5], 5'b0};
    n_exp = hit ? 0 : ((m_valid[idx] && m_dirty[idx]) ? 2 : 1);
    start = txn_q.size();
    @(posedge clk_i);
    #1;
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    stalls = 0;
    @(negedge clk_i);
    while (cpu_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk_i);
    end
    if (stalls >= 200) check_eq("stall_timeout", 1, 0);
    check_eq("txn_count", 256'(txn_q.size() - start), 256'(n_exp));
    sum_lat = 0;
    for (int i = start; i < txn_q.size(); i++) begin
      sum_lat += txn_q[i].lat;
      if (i - start < n_exp) begin
        if (n_exp == 2 && i == start) begin
          check_eq("wb_we", txn_q[i].we, 1'b1);
          check_eq("wb_addr", txn_q[i].addr, vaddr);
          check_eq("wb_data", txn_q[i].data, gold_line(vaddr));
        end else begin
          check_eq("fetch_we", txn_q[i].we, 1'b0);
          check_eq("fetch_addr", txn_q[i].addr, laddr);
        end
      end
    end
    check_eq("stall_cycles", 256'(stalls), hit ? 256'(0) : 256'(1 + sum_lat));
    check_eq("mem_req_idle", mem_req_o, 1'b0);
    if (!we) check_eq("load_data", cpu_data_o, gold_word(waddr));
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    if (we) golden[waddr] = wdata;
    m_dirty[idx] = (hit ? m_dirty[idx] : 1'b0) | we;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
  endtask

  initial begin
    logic [255:0] wb_line;
    logic [31:0]  a;
    rst_i      = 1'b1;
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    repeat (3) @(negedge clk_i);
    check_eq("rst_stall", cpu_stall_o, 1'b0);
    check_eq("rst_mem_req", mem_req_o, 1'b0);
    check_eq("rst_mem_we", mem_we_o, 1'b0);
    check_eq("rst_cpu_data", cpu_data_o, 32'h0);
    check_eq("rst_mem_addr", mem_addr_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset while a refill is outstanding aborts it at once.
    hold_ack = 1'b1;
    @(posedge clk_i);
    #1;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0200;
    repeat (4) @(negedge clk_i);
    check_eq("alloc_req", mem_req_o, 1'b1);
    check_eq("alloc_we", mem_we_o, 1'b0);
    check_eq("alloc_addr", mem_addr_o, 32'h0000_0200);
    #2 rst_i = 1'b1;
    #1 check_eq("abort_mem_req", mem_req_o, 1'b0);
    cpu_req_i = 1'b0;
    #1 check_eq("abort_stall", cpu_stall_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    hold_ack = 1'b0;
    do_access(1'b0, 32'h0000_0200, '0);

    // Cold load with a 10-cycle memory, then a repeat hit.
    fixed_lat = 10;
    do_access(1'b0, 32'h0000_0104, '0);
    fixed_lat = 0;
    do_access(1'b0, 32'h0000_0104, '0);

    // Dirty eviction by a conflicting load.
    do_access(1'b1, 32'h0000_0108, 32'hDEAD_BEEF);
    do_access(1'b0, 32'h0000_0908, '0);
    if (txn_q.size() >= 2) begin
      wb_line = txn_q[txn_q.size() - 2].data;
      check_eq("wb_word2", wb_line[95:64], 32'hDEAD_BEEF);
    end else begin
      check_eq("wb_present", 256'(txn_q.size()), 256'(2));
    end

    // Store miss to a clean line, then evict it.
    do_access(1'b1, 32'h0000_0044, 32'h1234_5678);
    do_access(1'b0, 32'h0000_1044, '0);

    // Stray ack while idle must leave everything untouched.
    stray_cnt++;
    repeat (3) @(negedge clk_i);
    do_access(1'b0, 32'h0000_090C, '0);
    do_access(1'b0, 32'h0000_1040, '0);

    for (int n = 0; n < 400; n++) begin
      a = {21'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 2'b00};
      do_access(1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
